// File: rtl/psimd_addsub_pipe_if.sv
// Handshake and data bundle for the packed-SIMD add/subtract pipeline.
// The master side is the producer/consumer environment; the slave side is the unit.
interface psimd_addsub_pipe_if #(
    parameter int LANE_W = 8,
    parameter int LANES  = 2
);
    localparam int DW = LANE_W * LANES;

    logic             in_valid;
    logic             in_ready;
    logic [DW-1:0]    in1;
    logic [DW-1:0]    in2;
    logic [1:0]       op;
    logic             sat_en;
    logic             out_valid;
    logic             out_ready;
    logic [DW-1:0]    out;
    logic [LANES-1:0] sat_lanes;
    logic [LANES-1:0] sticky_sat;
    logic             sticky_clr;

    modport master (
        output in_valid, in1, in2, op, sat_en, out_ready, sticky_clr,
        input  in_ready, out_valid, out, sat_lanes, sticky_sat
    );

    modport slave (
        input  in_valid, in1, in2, op, sat_en, out_ready, sticky_clr,
        output in_ready, out_valid, out, sat_lanes, sticky_sat
    );
endinterface

// File: rtl/psimd_addsub_pipe.sv
// Two-stage packed-SIMD add/subtract with per-lane signed/unsigned saturation
// and sticky overflow status. Stage A holds operands, stage B holds results.
module psimd_addsub_pipe #(
    parameter int LANE_W = 8,
    parameter int LANES  = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    psimd_addsub_pipe_if.slave    bus
);
    localparam int DW = LANE_W * LANES;

    // One lane: returns {overflow, result}; no carry leaves the lane.
    function automatic logic [LANE_W:0] lane_op(
        input logic [LANE_W-1:0] a,
        input logic [LANE_W-1:0] b,
        input logic              sub,
        input logic              uns,
        input logic              sat
    );
        logic [LANE_W:0]   raw;
        logic              ovf;
        logic [LANE_W-1:0] clamp;
        logic [LANE_W-1:0] res;
        if (sub) begin
            raw = {1'b0, a} - {1'b0, b};
        end else begin
            raw = {1'b0, a} + {1'b0, b};
        end
        if (uns) begin
            ovf   = raw[LANE_W];
            clamp = sub ? {LANE_W{1'b0}} : {LANE_W{1'b1}};
        end else begin
            if (sub) begin
                ovf = (a[LANE_W-1] != b[LANE_W-1]) && (raw[LANE_W-1] != a[LANE_W-1]);
            end else begin
                ovf = (a[LANE_W-1] == b[LANE_W-1]) && (raw[LANE_W-1] != a[LANE_W-1]);
            end
            // Overflow direction follows in1's sign for both add and sub.
            clamp = a[LANE_W-1] ? {1'b1, {(LANE_W-1){1'b0}}} : {1'b0, {(LANE_W-1){1'b1}}};
        end
        if (sat && ovf) begin
            res = clamp;
        end else begin
            res = raw[LANE_W-1:0];
        end
        return {ovf, res};
    endfunction

    logic             valid_a_r;
    logic [DW-1:0]    in1_a_r;
    logic [DW-1:0]    in2_a_r;
    logic [1:0]       op_a_r;
    logic             sat_en_a_r;
    logic             out_valid_r;
    logic [DW-1:0]    out_r;
    logic [LANES-1:0] sat_r;
    logic [LANES-1:0] sticky_r;

    logic             adv_b_s;
    logic             adv_a_s;
    logic             hs_out_s;
    logic [DW-1:0]    out_nxt_s;
    logic [LANES-1:0] sat_nxt_s;
    logic [LANE_W:0]  lane_s;

    assign adv_b_s  = ~out_valid_r | bus.out_ready;
    assign adv_a_s  = ~valid_a_r | adv_b_s;
    assign hs_out_s = out_valid_r & bus.out_ready;

    // Evaluate every lane from the stage-A registers.
    always_comb begin
        out_nxt_s = {DW{1'b0}};
        sat_nxt_s = {LANES{1'b0}};
        lane_s    = {(LANE_W+1){1'b0}};
        for (int i = 0; i < LANES; i++) begin
            lane_s = lane_op(in1_a_r[i*LANE_W +: LANE_W], in2_a_r[i*LANE_W +: LANE_W],
                             op_a_r[0], op_a_r[1], sat_en_a_r);
            out_nxt_s[i*LANE_W +: LANE_W] = lane_s[LANE_W-1:0];
            sat_nxt_s[i]                  = lane_s[LANE_W];
        end
    end

    // Stage A: capture operands and mode on an input handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_a_r  <= 1'b0;
            in1_a_r    <= {DW{1'b0}};
            in2_a_r    <= {DW{1'b0}};
            op_a_r     <= 2'b00;
            sat_en_a_r <= 1'b0;
        end else if (adv_a_s) begin
            valid_a_r <= bus.in_valid;
            if (bus.in_valid) begin
                in1_a_r    <= bus.in1;
                in2_a_r    <= bus.in2;
                op_a_r     <= bus.op;
                sat_en_a_r <= bus.sat_en;
            end
        end
    end

    // Stage B: register results; last values linger when the stage empties.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            out_r       <= {DW{1'b0}};
            sat_r       <= {LANES{1'b0}};
        end else if (adv_b_s) begin
            out_valid_r <= valid_a_r;
            if (valid_a_r) begin
                out_r <= out_nxt_s;
                sat_r <= sat_nxt_s;
            end
        end
    end

    // Sticky status: a clear coinciding with a handshake keeps that beat's flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_r <= {LANES{1'b0}};
        end else if (hs_out_s) begin
            sticky_r <= (bus.sticky_clr ? {LANES{1'b0}} : sticky_r) | sat_r;
        end else if (bus.sticky_clr) begin
            sticky_r <= {LANES{1'b0}};
        end
    end

    assign bus.in_ready   = adv_a_s;
    assign bus.out_valid  = out_valid_r;
    assign bus.out        = out_r;
    assign bus.sat_lanes  = sat_r;
    assign bus.sticky_sat = sticky_r;
endmodule
